cu_issue_sched: RTL

Issue scheduler for the compute unit. Buffers compute requests from the program sequencer, tracks pending register-file writes in a scoreboard, and issues each request to the ALU, shifter or multiplier only when it has no data hazard and no write-port conflict. It drives the unit enables, the register read addresses, and the one-hot crossbar write-select with the write address at each result's retire cycle.

---
 rtl/cu_issue_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cu_issue_sched.sv
// cu_issue_sched: in-order issue scheduler with request FIFO, register scoreboard and a single-write-port retire pipeline.
module cu_issue_sched #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3,
  parameter int MUL_LAT       = 2,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk_exe,
  input  logic                     reset,
  input  logic                     stallb,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_unit,
  input  logic [ADDRESS_WIDTH-1:0] req_rx,
  input  logic [ADDRESS_WIDTH-1:0] req_ry,
  input  logic [ADDRESS_WIDTH-1:0] req_rd,
  input  logic                     req_wb,
  output logic                     iss_alu_en,
  output logic                     iss_shf_en,
  output logic                     iss_mul_en,
  output logic [ADDRESS_WIDTH-1:0] iss_raddx,
  output logic [ADDRESS_WIDTH-1:0] iss_raddy,
  output logic [SIGNAL_WIDTH-1:0]  wb_cuEn,
  output logic [ADDRESS_WIDTH-1:0] wb_wadd,
  output logic                     busy,
  output logic                     err_illegal
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int NR = 2 ** AW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 + 3 * AW;
  localparam int SW = $clog2(MUL_LAT);
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rp, wp;
  logic [PW:0] cnt, cnt_n;
  logic up;
  logic [NR-1:0] sb, sb_clr, sb_set;
  logic [MUL_LAT-1:0] p_v;
  logic [SIGNAL_WIDTH-1:0] p_u [MUL_LAT];
  logic [AW-1:0] p_a [MUL_LAT];
  logic [1:0] h_unit;
  logic h_wb;
  logic [AW-1:0] h_rx, h_ry, h_rd;
  logic [SIGNAL_WIDTH-1:0] h_oh;
  logic h_ill, h_mul, haz, slot_ok, push, pop, iss, ins;
  logic [SW-1:0] slot;
  assign {h_unit, h_wb, h_rx, h_ry, h_rd} = mem[rp];
  assign h_ill = h_unit == 2'b11;
  assign h_mul = h_unit == 2'b10;
  assign h_oh = SIGNAL_WIDTH'(1) << h_unit;
  assign haz = sb[h_rx] | sb[h_ry] | (h_wb & sb[h_rd]);
  // ALU/shifter land in slot 0, which after the shift holds what is now in slot 1
  assign slot_ok = !h_wb | h_mul | !p_v[1];
  assign req_ready = up & stallb & (cnt != (PW+1)'(FIFO_DEPTH));
  assign push = req_valid & req_ready;
  assign pop = stallb & (cnt != '0) & (h_ill | (!haz & slot_ok));
  assign iss = pop & !h_ill;
  assign ins = iss & h_wb;
  assign slot = h_mul ? SW'(MUL_LAT - 1) : '0;
  assign cnt_n = cnt + (PW+1)'(push) - (PW+1)'(pop);
  assign sb_clr = p_v[0] ? NR'(1) << p_a[0] : '0;
  assign sb_set = ins ? NR'(1) << h_rd : '0;
  always_ff @(posedge clk_exe)
    if (push) mem[wp] <= {req_unit, req_wb, req_rx, req_ry, req_rd};
  always_ff @(posedge clk_exe or negedge reset) begin
    if (!reset) begin
      up <= 1'b0;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      sb <= '0;
      p_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        p_u[i] <= '0;
        p_a[i] <= '0;
      end
      iss_alu_en <= 1'b0;
      iss_shf_en <= 1'b0;
      iss_mul_en <= 1'b0;
      iss_raddx <= '0;
      iss_raddy <= '0;
      wb_cuEn <= '0;
      wb_wadd <= '0;
      busy <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      up <= 1'b1;
      rp <= rp + PW'(pop);
      wp <= wp + PW'(push);
      cnt <= cnt_n;
      iss_alu_en <= iss & (h_unit == 2'b00);
      iss_shf_en <= iss & (h_unit == 2'b01);
      iss_mul_en <= iss & h_mul;
      err_illegal <= pop & h_ill;
      if (iss) begin
        iss_raddx <= h_rx;
        iss_raddy <= h_ry;
      end
      busy <= (cnt_n != '0) | (|p_v) | ins;
      if (stallb) begin
        wb_cuEn <= p_v[0] ? p_u[0] : '0;
        wb_wadd <= p_v[0] ? p_a[0] : '0;
        sb <= (sb & ~sb_clr) | sb_set;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
          p_v[i] <= p_v[i+1];
          p_u[i] <= p_u[i+1];
          p_a[i] <= p_a[i+1];
        end
        p_v[MUL_LAT-1] <= 1'b0;
        if (ins) begin
          p_v[slot] <= 1'b1;
          p_u[slot] <= h_oh;
          p_a[slot] <= h_rd;
        end
      end else begin
        wb_cuEn <= '0;
        wb_wadd <= '0;
      end
    end
  end
endmodule
